// File: rtl/fp32_pkg.sv
// Shared definitions for the binary32 adder/subtractor.
//   EXP_BIAS / EXP_MAX : exponent bias and the all-ones (inf/NaN) exponent
//   QNAN / POS_INF     : canonical quiet NaN and +infinity encodings
//   fp32_t             : field view of a binary32 word
package fp32_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

endpackage

// File: rtl/fp32_cla_addsub_cla_adder.sv
// Carry-lookahead adder built from CLA_BLOCK-bit lookahead groups.
//   a_i, b_i : addends
//   cin_i    : carry into bit 0
//   sum_o    : a_i + b_i + cin_i (low WIDTH bits)
//   cout_o   : carry out of the top bit
// Inside a group every carry is formed directly from the generate/propagate
// terms and the group carry-in; group carries chain from group to group.
// CLA_BLOCK must divide WIDTH.
module cla_adder #(
  parameter int WIDTH     = 28,
  parameter int CLA_BLOCK = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int NGROUPS = WIDTH / CLA_BLOCK;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NGROUPS:0] gc;
  logic             term;
  logic             cval;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    c     = '0;
    gc    = '0;
    term  = 1'b0;
    cval  = 1'b0;
    gc[0] = cin_i;
    for (int n = 0; n < NGROUPS; n++) begin
      // k == CLA_BLOCK yields the group carry-out.
      for (int k = 0; k <= CLA_BLOCK; k++) begin
        cval = gc[n];
        for (int m = 0; m < k; m++) cval = cval & p[n*CLA_BLOCK+m];
        for (int j = 0; j < k; j++) begin
          term = g[n*CLA_BLOCK+j];
          for (int m = j + 1; m < k; m++) term = term & p[n*CLA_BLOCK+m];
          cval = cval | term;
        end
        if (k < CLA_BLOCK) c[n*CLA_BLOCK+k] = cval;
        else               gc[n+1]          = cval;
      end
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = gc[NGROUPS];

endmodule

// File: rtl/fp32_cla_addsub.sv
// Single-precision adder/subtractor, one-cycle registered latency.
//   clk, reset : clock and synchronous active-high reset
//   in_valid   : a, b, sub are valid this cycle
//   sub        : 0 -> a + b, 1 -> a - b
//   a, b       : binary32 operands (subnormals treated as signed zero)
//   out_valid  : in_valid delayed by one cycle
//   result     : registered result, holds while in_valid is low
// Handshake: an operation is taken on every rising edge where in_valid is 1;
// there is no ready, and out_valid is high for exactly the cycle after.
// Rounding is nearest-even; no subnormal outputs, no exception flags.
module fp32_cla_addsub
  import fp32_pkg::*;
#(
  parameter int CLA_BLOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] result
);

  fp32_t fa, fb, fl, fs;
  logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic  a_larger, eff_sub;
  logic [7:0]  exp_diff;
  logic [53:0] shift_full;
  logic [26:0] small_al;
  logic [27:0] cla_a, cla_b, cla_sum;
  logic        cla_cout, carry;
  logic [26:0] ext, norm;
  logic [4:0]  lzc;
  logic        found, rnd_up, rc;
  logic [22:0] frac;
  logic signed [9:0] exp_n, exp_r;
  logic [31:0] f_res;
  logic [31:0] result_q, result_d;
  logic        out_valid_q, out_valid_d;
  logic        unused_bits;

  assign fa = fp32_t'(a);
  assign fb = fp32_t'({b[31] ^ sub, b[30:0]});

  assign a_nan  = (fa.exp == 8'(EXP_MAX)) && (fa.man != '0);
  assign b_nan  = (fb.exp == 8'(EXP_MAX)) && (fb.man != '0);
  assign a_inf  = (fa.exp == 8'(EXP_MAX)) && (fa.man == '0);
  assign b_inf  = (fb.exp == 8'(EXP_MAX)) && (fb.man == '0);
  assign a_zero = (fa.exp == 8'd0);
  assign b_zero = (fb.exp == 8'd0);

  assign a_larger = {fa.exp, fa.man} >= {fb.exp, fb.man};
  assign fl       = a_larger ? fa : fb;
  assign fs       = a_larger ? fb : fa;
  assign eff_sub  = fa.sign ^ fb.sign;
  assign exp_diff = fl.exp - fs.exp;

  // Alignment: the 27-bit window is {mantissa, guard, round, sticky}; every
  // bit falling below the window is ORed into the sticky position.
  assign shift_full = {1'b1, fs.man, 3'b000, 27'd0} >> exp_diff;
  assign small_al   = (exp_diff >= 8'd27) ? 27'd1
                                          : {shift_full[53:28], |shift_full[27:0]};

  // One spare LSB keeps the 28-bit adder aligned with the top-bit carry-out.
  assign cla_a = {1'b1, fl.man, 4'b0000};
  assign cla_b = eff_sub ? ~{small_al, 1'b0} : {small_al, 1'b0};

  cla_adder #(.WIDTH(28), .CLA_BLOCK(CLA_BLOCK)) u_cla (
    .a_i   (cla_a),
    .b_i   (cla_b),
    .cin_i (eff_sub),
    .sum_o (cla_sum),
    .cout_o(cla_cout)
  );

  // On a subtraction the carry-out only signals "no borrow"; it is not growth.
  assign carry = cla_cout & ~eff_sub;
  assign ext   = {cla_sum[27:2], cla_sum[1] | cla_sum[0]};

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && ext[i]) begin
        lzc   = 5'(26 - i);
        found = 1'b1;
      end
    end
    if (carry) begin
      norm  = {1'b1, ext[26:2], ext[1] | ext[0]};
      exp_n = $signed({2'b00, fl.exp}) + 10'sd1;
    end else begin
      norm  = ext << lzc;
      exp_n = $signed({2'b00, fl.exp}) - $signed({5'd0, lzc});
    end
    rnd_up      = norm[2] & (norm[1] | norm[0] | norm[3]);
    // A fraction wrap leaves frac at zero, which is the renormalized value.
    {rc, frac}  = {1'b0, norm[25:3]} + 24'(rnd_up);
    exp_r       = exp_n + $signed({9'd0, rc});
  end

  always_comb begin
    if (a_nan || b_nan)                          f_res = QNAN;
    else if (a_inf && b_inf && eff_sub)          f_res = QNAN;
    else if (a_inf)                              f_res = fa;
    else if (b_inf)                              f_res = fb;
    else if (a_zero && b_zero)                   f_res = {fa.sign & fb.sign, 31'd0};
    else if (a_zero)                             f_res = fb;
    else if (b_zero)                             f_res = fa;
    else if (!carry && ext == '0)                f_res = 32'd0;
    else if (exp_r >= 10'sd255)                  f_res = {fl.sign, POS_INF[30:0]};
    else if (exp_r <= 10'sd0)                    f_res = {fl.sign, 31'd0};
    else                                         f_res = {fl.sign, exp_r[7:0], frac};
  end

  // The hidden bit of the normalized mantissa is implicit in the encoding.
  assign unused_bits = norm[26];

  assign out_valid_d = in_valid;
  assign result_d    = in_valid ? f_res : result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fp32_cla_addsub.sv
module tb_fp32_cla_addsub;
  import fp32_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result;

  always #5 clk = ~clk;

  fp32_cla_addsub #(.CLA_BLOCK(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .result   (result)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real to_real(input logic [31:0] x);
    real v;
    if (x[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (real'(x[30:23]) - 127.0));
    return x[31] ? -v : v;
  endfunction

  // Double -> binary32, nearest-even, flush-to-zero, overflow to inf.
  function automatic logic [31:0] round_f32(input real x);
    logic [63:0] bits;
    logic [52:0] m53;
    logic [23:0] top;
    logic [28:0] rem;
    logic        up;
    logic [24:0] t;
    int          fe;
    bits = $realtobits(x);
    m53  = {1'b1, bits[51:0]};
    top  = m53[52:29];
    rem  = m53[28:0];
    fe   = int'(bits[62:52]) - 1023 + 127;
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && top[0]);
    t    = {1'b0, top} + 25'(up);
    if (t[24]) begin
      fe++;
      t = t >> 1;
    end
    if (fe >= 255) return {bits[63], 8'hFF, 23'd0};
    if (fe <= 0)   return {bits[63], 31'd0};
    return {bits[63], 8'(fe), t[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    logic [31:0] be;
    logic        an, bn, ai, bi, az, bz;
    real         x;
    be = {tb_v[31] ^ ts, tb_v[30:0]};
    an = (ta[30:23] == 8'hFF) && (ta[22:0] != 0);
    bn = (be[30:23] == 8'hFF) && (be[22:0] != 0);
    ai = (ta[30:23] == 8'hFF) && (ta[22:0] == 0);
    bi = (be[30:23] == 8'hFF) && (be[22:0] == 0);
    az = (ta[30:23] == 8'd0);
    bz = (be[30:23] == 8'd0);
    if (an || bn) return 32'h7FC0_0000;
    if (ai && bi && (ta[31] != be[31])) return 32'h7FC0_0000;
    if (ai) return ta;
    if (bi) return be;
    if (az && bz) return {ta[31] & be[31], 31'd0};
    if (az) return be;
    if (bz) return ta;
    x = to_real(ta) + to_real(be);
    if (x == 0.0) return 32'd0;
    return round_f32(x);
  endfunction

  function automatic logic [31:0] rand_b(input logic [31:0] ta);
    int e;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: begin
        e = int'(ta[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
      end
      2: return {~ta[31], ta[30:0]} ^ 32'($urandom_range(0, 255));
      default: begin
        case ($urandom_range(0, 7))
          0: return 32'h0000_0000;
          1: return 32'h8000_0000;
          2: return 32'h7F80_0000;
          3: return 32'hFF80_0000;
          4: return 32'h7FC0_0000;
          5: return 32'h0000_0005;
          6: return 32'h7F7F_FFFF;
          default: return 32'h0080_0000;
        endcase
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Leaves in_valid high so consecutive calls are back-to-back operations.
  task automatic apply(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input logic [31:0] expv, input string tag);
    a        = ta;
    b        = tb_v;
    sub      = ts;
    in_valid = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, result, last_exp);
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_hold"}, result, last_exp);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    reset    = 1'b1;
    in_valid = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;

    apply(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, "add_1_2");
    idle("after_add");
    apply(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, "sub_3_1");
    apply(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, "sub_cancel");
    apply(32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, "add_cancel");
    apply(32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, "add_mixed");
    apply(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, "tie_even");
    apply(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, "tie_up");
    apply(32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h3F80_0000, "subnorm_ftz");
    apply(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, "overflow");
    apply(32'h7F80_0000, 32'h7F80_0000, 1'b1, QNAN,          "inf_minus_inf");
    apply(32'h7FC0_0001, 32'h3F80_0000, 1'b0, QNAN,          "nan_in");
    apply(32'hFF80_0000, 32'h4000_0000, 1'b0, 32'hFF80_0000, "neg_inf");
    apply(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, "neg_zero_sub");
    idle("hold_after_run");

    // Reset wins over a simultaneous operation.
    apply(32'h4040_0000, 32'h4040_0000, 1'b0, 32'h40C0_0000, "pre_reset");
    reset = 1'b1;
    a     = 32'h3F80_0000;
    b     = 32'h3F80_0000;
    @(posedge clk);
    #1;
    check("reset_vs_valid_result", result, 32'd0);
    check("reset_vs_valid_valid", {31'd0, out_valid}, 32'd0);
    reset    = 1'b0;
    last_exp = 32'd0;
    idle("post_reset");

    // Four back-to-back operations.
    apply(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000, "b2b_0");
    apply(32'h4080_0000, 32'h3F80_0000, 1'b1, 32'h4040_0000, "b2b_1");
    apply(32'h3F00_0000, 32'h3F00_0000, 1'b0, 32'h3F80_0000, "b2b_2");
    apply(32'hC120_0000, 32'h4120_0000, 1'b1, 32'hC1A0_0000, "b2b_3");
    idle("b2b_hold");

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[30:23] = 8'($urandom_range(100, 154));
      rb = rand_b(ra);
      rs = 1'($urandom_range(0, 1));
      apply(ra, rb, rs, model(ra, rb, rs), "random");
      if ($urandom_range(0, 3) == 0) idle("random_idle");
    end
    idle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_cla_addsub.md
Name: fp32_cla_addsub

Overview:
Single-precision IEEE-754 floating-point adder/subtractor. The mantissa datapath uses a carry-lookahead adder. It provides both the add and subtract functions (result = a + b or a - b) behind one op select. The state machine uses it to compute the result word for its ADD and SUBTRACT tasks. The output is registered, giving a one-cycle latency.

Parameters:
CLA_BLOCK, 4, width of each carry-lookahead group inside the mantissa adder (must divide 28)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all registers
in_valid  input  1  operands/op valid this cycle
sub  input  1  0: a + b, 1: a - b
a  input  32  operand A, IEEE-754 binary32
b  input  32  operand B, IEEE-754 binary32
out_valid  output  1  result valid (in_valid delayed one cycle)
result  output  32  registered sum/difference

Behaviour:
- Reset (synchronous, active-high): result = 32'h0000_0000, out_valid = 0. Reset has priority over in_valid in the same cycle. An operation in flight is dropped.
- Latency is exactly 1 cycle.
  - result and out_valid update on every rising edge.
  - out_valid <= in_valid.
  - result <= f(a, b, sub) when in_valid = 1; otherwise result holds its value.
- No backpressure; one operation can be accepted per cycle.
- Subtract is implemented as the add datapath with the sign of b inverted (b_eff).
- Subnormal inputs (exp = 0) are flushed to signed zero before the operation.
- Special cases, in priority order:
  1. Either operand NaN -> 32'h7FC0_0000.
  2. inf + (-inf) (after b_eff) -> 32'h7FC0_0000.
  3. Either operand inf -> that inf with its own sign.
  4. Both operands zero -> sign = sign_a AND sign_b_eff.
  5. One operand zero -> the other operand (b_eff when a is zero).
- Normal path:
  - Prepend the hidden 1 to each mantissa.
  - Swap operands so the larger magnitude (compared by exp, then mantissa) is first.
  - Right-shift the smaller mantissa by the exponent difference, capturing guard, round and sticky bits. A shift of 27 or more leaves only the sticky bit.
  - Add or subtract the 28-bit extended mantissas with the CLA (a subtraction uses the two's complement of the smaller).
  - Result sign is the sign of the larger operand.
  - An exact zero difference gives +0.
- Normalization:
  - On carry-out, shift right 1 (folding the shifted-out bit into sticky) and increment the exponent.
  - Otherwise, left-shift by the leading-zero count and decrement the exponent.
- Rounding is round-to-nearest, ties-to-even, using guard/round/sticky. A mantissa carry from rounding renormalizes and increments the exponent.
- Exponent at or above 255 after rounding -> signed infinity (exp = 255, mantissa = 0).
- Exponent at or below 0 -> signed zero (flush-to-zero, no subnormal outputs).
- No exception flags are produced.

Decomposition:
- Package fp32_pkg holds:
  - constants EXP_BIAS = 127, EXP_MAX = 255, QNAN = 32'h7FC0_0000, POS_INF = 32'h7F80_0000;
  - a typedef fp32_t with fields sign, exp[7:0] and man[22:0].
- One sub-module is natural: cla_adder, a WIDTH = 28 carry-lookahead adder built from CLA_BLOCK-bit lookahead groups with carry-in and carry-out.
- The leading-zero count and rounding logic stay inline.

Test Plan:
- Basic add and subtract:
  - Add 3F80_0000 + 4000_0000 -> 4040_0000 (1.0 + 2.0 = 3.0).
  - Subtract 4040_0000 - 3F80_0000 -> 4000_0000.
  - out_valid rises exactly 1 cycle after in_valid.
- Cancellation and mixed signs:
  - Subtract 3F80_0000 - 3F80_0000 -> 0000_0000.
  - Add 3F80_0000 + BF80_0000 -> 0000_0000.
  - Add C000_0000 + 3F80_0000 -> BF80_0000.
- Rounding ties:
  - Add 3F80_0000 + 3380_0000 -> 3F80_0000 (tie, even kept).
  - Add 3F80_0001 + 3380_0000 -> 3F80_0002 (tie, rounds up).
  - Add 3F80_0000 + 0000_0001 (subnormal flushed to zero) -> 3F80_0000.
- Overflow and specials:
  - Add 7F7F_FFFF + 7F7F_FFFF -> 7F80_0000.
  - Subtract 7F80_0000 - 7F80_0000 -> 7FC0_0000.
  - Add 7FC0_0001 + 3F80_0000 -> 7FC0_0000.
  - Add FF80_0000 + 4000_0000 -> FF80_0000.
- Reset and throughput:
  - Assert reset in the same cycle as in_valid = 1 -> next cycle result = 0000_0000 and out_valid = 0.
  - Back-to-back in_valid for 4 cycles -> 4 consecutive correct results.
  - in_valid = 0 -> result holds its value.
